// File: rtl/fetch_queue_pkg.sv
// Shared fetch types: instruction/address widths, halt word, queue entry struct.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_queue_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [INSTR_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// Bundles the instruction-RAM read port and the decode handshake of the fetch stage.
// Latency: n/a (wires only); imem_data is expected one cycle after imem_en.
// Backpressure: decode stalls the queue by holding dec_ready low.
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  logic               imem_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               dec_valid;
  logic               dec_ready;
  logic [INSTR_W-1:0] dec_instr;
  logic [ADDR_W-1:0]  dec_pc;

  modport master (
    output imem_en, imem_addr, dec_valid, dec_instr, dec_pc,
    input  imem_data, dec_ready
  );

  modport slave (
    input  imem_en, imem_addr, dec_valid, dec_instr, dec_pc,
    output imem_data, dec_ready
  );
endinterface

// File: rtl/fetch_queue_fifo.sv
// Synchronous entry FIFO with flush; head entry is read combinationally.
// Latency: a push becomes visible at the head the cycle after it is written.
// Backpressure: none internally; the owner must never push when full or pop when empty.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_dat,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [AW:0]  count
);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // Storage, pointers and count; flush empties the queue but keeps stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: sequential PC generation, credit-limited imem reads, entry queue to decode.
// Latency: issue to dec_valid 2 cycles; redirect to first dec_valid 3 cycles.
// Backpressure: issue stops when queued + in-flight reads reach DEPTH. Optional halt: FETCHQ_HALT_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] PC_STEP  = 32'd4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fetch_queue_if.master           bus,
  input  logic                    redirect,
  input  logic [ADDR_W-1:0]       redirect_pc,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    halted
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [CW-1:0]     count;
  logic [CW:0]       used;
  logic              issue;
  logic              push;
  logic              pop;
  fetch_entry_t      head;
  fetch_entry_t      push_dat;

  // Queued entries plus the read in flight form the credit that gates issue.
  assign used  = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue = rst_n && !redirect && !halted && (used < DEPTH_C);
  assign push  = inflight && !redirect;
  assign pop   = bus.dec_valid && bus.dec_ready;

  assign push_dat.instr = bus.imem_data;
  assign push_dat.pc    = inflight_pc;

  assign bus.imem_en   = issue;
  assign bus.imem_addr = fetch_pc;
  assign bus.dec_valid = (count != '0);
  assign bus.dec_instr = head.instr;
  assign bus.dec_pc    = head.pc;
  assign occupancy     = count;

  // PC and in-flight tracking; redirect retargets fetch and drops the pending read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + PC_STEP;
        inflight_pc <= fetch_pc;
      end
    end
  end

`ifdef FETCHQ_HALT_EN
  logic halt_q;

  // Halt latches when the halt word is written into the queue; only redirect clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                halt_q <= 1'b0;
    else if (redirect)                         halt_q <= 1'b0;
    else if (push && bus.imem_data == HALT_WORD) halt_q <= 1'b1;
  end

  assign halted = halt_q;
`else
  assign halted = 1'b0;
`endif

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, streaming, stall/credit, redirect, wrap, halt.
// Latency: checks cycle-exact issue and delivery timing against hand-computed values.
// Backpressure: exercised by holding and pulsing dec_ready.
module tb_fetch_queue;
  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  occ;
  logic        halted;
  logic [31:0] halt_addr;
  int          n_cmp;
  int          n_err;

  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .occupancy   (occ),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction RAM model: one-cycle read, data = addr + 0x100, or the halt word at halt_addr.
  always @(posedge clk) begin
    if (bus.imem_en)
      bus.imem_data <= (bus.imem_addr == halt_addr) ? 32'hFFFF_FFFF : bus.imem_addr + 32'h100;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Assert reset, check reset outputs, release at a negedge; returns inside cycle 0.
  task automatic do_reset();
    rst_n    = 1'b0;
    redirect = 1'b0;
    #1;
    chk("rst_en",     32'(bus.imem_en),   32'd0);
    chk("rst_addr",   bus.imem_addr,      32'h0);
    chk("rst_valid",  32'(bus.dec_valid), 32'd0);
    chk("rst_instr",  bus.dec_instr,      32'h0);
    chk("rst_pc",     bus.dec_pc,         32'h0);
    chk("rst_occ",    32'(occ),           32'd0);
    chk("rst_halted", 32'(halted),        32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("c0_en",   32'(bus.imem_en), 32'd1);
    chk("c0_addr", bus.imem_addr,    32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  occ_tab [8];
    logic [31:0] exp_pc;
    int          pops;
    logic        halt_on;

    occ_tab = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
`ifdef FETCHQ_HALT_EN
    halt_on = 1'b1;
`else
    halt_on = 1'b0;
`endif
    n_cmp         = 0;
    n_err         = 0;
    halt_addr     = 32'h1;
    redirect      = 1'b0;
    redirect_pc   = 32'h0;
    bus.dec_ready = 1'b1;
    bus.imem_data = 32'h0;

    // Streaming with decode always ready: one issue and one delivery per cycle.
    do_reset();
    for (int k = 1; k < 10; k++) begin
      cyc();
      chk("t1_en",   32'(bus.imem_en), 32'd1);
      chk("t1_addr", bus.imem_addr,    32'(4 * k));
      if (k >= 2) begin
        chk("t1_valid", 32'(bus.dec_valid), 32'd1);
        chk("t1_pc",    bus.dec_pc,         32'(4 * (k - 2)));
        chk("t1_instr", bus.dec_instr,      32'(4 * (k - 2)) + 32'h100);
        chk("t1_occ",   32'(occ),           32'd1);
      end else begin
        chk("t1_valid0", 32'(bus.dec_valid), 32'd0);
      end
    end

    // Decode stalled from reset: exactly four issues, queue saturates.
    bus.dec_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc();
      chk("t2_en",   32'(bus.imem_en), (k < 4) ? 32'd1 : 32'd0);
      chk("t2_addr", bus.imem_addr,    (k < 4) ? 32'(4 * k) : 32'h10);
      chk("t2_occ",  32'(occ),         32'(occ_tab[k]));
    end
    cyc();
    bus.dec_ready = 1'b1;
    #1;
    chk("t3_valid", 32'(bus.dec_valid), 32'd1);
    chk("t3_pc",    bus.dec_pc,         32'h0);
    chk("t3_en",    32'(bus.imem_en),   32'd0);
    chk("t3_occ",   32'(occ),           32'd4);
    cyc();
    bus.dec_ready = 1'b0;
    #1;
    chk("t3_occ3",  32'(occ),         32'd3);
    chk("t3_en1",   32'(bus.imem_en), 32'd1);
    chk("t3_addr",  bus.imem_addr,    32'h10);
    cyc();
    chk("t3_occ3b", 32'(occ),         32'd3);
    chk("t3_en0",   32'(bus.imem_en), 32'd0);
    cyc();
    chk("t3_occ4",  32'(occ),         32'd4);
    chk("t3_en0b",  32'(bus.imem_en), 32'd0);
    chk("t3_head",  bus.dec_pc,       32'h4);
    bus.dec_ready = 1'b1;
    #1;
    exp_pc = 32'h4;
    pops   = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.dec_valid) begin
        chk("t2_drain_pc",    bus.dec_pc,    exp_pc);
        chk("t2_drain_instr", bus.dec_instr, exp_pc + 32'h100);
        exp_pc = exp_pc + 32'h4;
        pops++;
      end
      cyc();
    end
    chk("t2_pops", 32'(pops), 32'd12);

    // Redirect while the addr-8 response returns: response dropped, restart at 0x200.
    do_reset();
    cyc(); cyc(); cyc();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    #1;
    chk("t4_en_r",  32'(bus.imem_en), 32'd0);
    chk("t4_pc_r",  bus.dec_pc,       32'h4);
    cyc();
    redirect = 1'b0;
    #1;
    chk("t4_occ",    32'(occ),           32'd0);
    chk("t4_valid1", 32'(bus.dec_valid), 32'd0);
    chk("t4_en1",    32'(bus.imem_en),   32'd1);
    chk("t4_addr1",  bus.imem_addr,      32'h200);
    cyc();
    chk("t4_valid2", 32'(bus.dec_valid), 32'd0);
    chk("t4_addr2",  bus.imem_addr,      32'h204);
    cyc();
    chk("t4_valid3", 32'(bus.dec_valid), 32'd1);
    chk("t4_pc3",    bus.dec_pc,         32'h200);
    chk("t4_instr3", bus.dec_instr,      32'h300);
    cyc();
    chk("t4_pc4",    bus.dec_pc,         32'h204);

    // Address wrap from the top of the address space.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    #1;
    chk("t5_en_r", 32'(bus.imem_en), 32'd0);
    cyc();
    redirect = 1'b0;
    #1;
    chk("t5_addr1", bus.imem_addr, 32'hFFFF_FFFC);
    cyc();
    chk("t5_addr2", bus.imem_addr, 32'h0);
    cyc();
    chk("t5_pc3",    bus.dec_pc,    32'hFFFF_FFFC);
    chk("t5_instr3", bus.dec_instr, 32'h0000_00FC);
    cyc();
    chk("t5_pc4",    bus.dec_pc,    32'h0);
    chk("t5_instr4", bus.dec_instr, 32'h100);

    // Halt word at addr 8: halts fetch when enabled, ordinary data otherwise.
    halt_addr = 32'h8;
    do_reset();
    cyc(); cyc(); cyc();
    chk("t6_halt_c3", 32'(halted), 32'd0);
    cyc();
    chk("t6_halt_c4",  32'(halted),       halt_on ? 32'd1 : 32'd0);
    chk("t6_en_c4",    32'(bus.imem_en),  halt_on ? 32'd0 : 32'd1);
    chk("t6_pc_c4",    bus.dec_pc,        32'h8);
    chk("t6_instr_c4", bus.dec_instr,     32'hFFFF_FFFF);
    cyc();
    chk("t6_pc_c5",    bus.dec_pc,        32'hC);
    chk("t6_en_c5",    32'(bus.imem_en),  halt_on ? 32'd0 : 32'd1);
    cyc();
    chk("t6_valid_c6", 32'(bus.dec_valid), halt_on ? 32'd0 : 32'd1);
    chk("t6_en_c6",    32'(bus.imem_en),   halt_on ? 32'd0 : 32'd1);
    cyc();
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    #1;
    cyc();
    redirect = 1'b0;
    #1;
    chk("t6_halt_clr", 32'(halted),       32'd0);
    chk("t6_en_res",   32'(bus.imem_en),  32'd1);
    chk("t6_addr_res", bus.imem_addr,     32'h0);
    halt_addr = 32'h1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage with a buffering queue. It sits between the PC/instruction-memory pair and the decode/register-read stage. It generates sequential fetch addresses and issues single-cycle synchronous reads to instruction RAM. It buffers returned instructions with their PCs in a DEPTH-entry FIFO and hands them to decode over a valid/ready handshake. On a taken branch or jump from the execute stage it flushes everything, including a read still in flight.

## Interface
- DEPTH, 4: queue entries; power of two, 2..16
- RESET_PC, 32'h0000_0000: first fetch address after reset
- PC_STEP, 4: sequential address increment
- CLOCK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-low reset (decided: single clock, async active-low reset)
- redirect  in  1  taken branch/jump from execute; overrides everything
- redirect_pc  in  32  new fetch target, sampled when redirect=1
- imem_en  out  1  instruction RAM read enable
- imem_addr  out  32  instruction RAM fetch address
- imem_data  in  32  read data, valid the cycle after imem_en=1
- dec_valid  out  1  head entry valid
- dec_ready  in  1  decode accepts head entry
- dec_instr  out  32  head instruction
- dec_pc  out  32  PC of head instruction
- occupancy  out  $clog2(DEPTH)+1  entries currently stored
- halted  out  1  halt detected (only with the macro, otherwise 0)

## Operation
- State: fetch_pc, inflight flag, inflight_pc, FIFO (instr, pc) with rd/wr pointers and count.
- Issue: imem_en = !redirect && !halted && (count + inflight) < DEPTH. When set, imem_addr = fetch_pc. Next fetch_pc = fetch_pc + PC_STEP, wrapping mod 2^32. inflight <= 1 and inflight_pc <= fetch_pc.
- imem_addr holds fetch_pc whenever imem_en=0.
- Response: when inflight=1, enqueue {imem_data, inflight_pc} this cycle. inflight clears unless a new issue occurs.
- Credit rule: count + inflight never exceeds DEPTH, so an enqueue never finds the queue full.
- Dequeue: pop when dec_valid && dec_ready. dec_valid = (count != 0). dec_instr/dec_pc are driven directly from the head entry.
- Push and pop in the same cycle: count unchanged. This is legal at count=DEPTH (pop frees the slot written) and at count=0 never occurs (a push lands at the tail and is not visible until the next cycle).
- Redirect (highest priority):
  - count <= 0, pointers reset, inflight <= 0; the response arriving this cycle is discarded.
  - fetch_pc <= redirect_pc; halted <= 0.
  - No issue in the redirect cycle. A pop in that cycle is still counted as consumed.
- Reset mid-operation clears all state immediately. Outputs: imem_en=0 while RESET is low, imem_addr=RESET_PC, dec_valid=0, dec_instr=0, dec_pc=0, occupancy=0, halted=0.

## Timing
- Cycle 0 is the first edge after RESET deasserts. imem_en=1 and imem_addr=RESET_PC are combinational from state during cycle 0.
- Issue-to-dec_valid latency: 2 cycles. Issue in cycle n, data in cycle n+1 with enqueue at the end of n+1, dec_valid in n+2.
- Redirect-to-first-valid latency: redirect in cycle r, issue of redirect_pc in r+1, dec_valid in r+3.
- Steady-state throughput with dec_ready held high: 1 instruction/cycle.
- occupancy is registered count; it excludes inflight.

## Configuration
- FETCHQ_HALT_EN defined:
  - An enqueued instruction equal to 32'hFFFF_FFFF sets halted the same edge it is written.
  - While halted, no further issues. Queued entries, including the halt word, still drain to decode.
  - Only redirect or reset clears halted.
- FETCHQ_HALT_EN undefined: halted is tied 0 and 32'hFFFF_FFFF is an ordinary instruction.

## Structure
- Shared cpu package: INSTR_W=32, ADDR_W=32, HALT_WORD=32'hFFFF_FFFF, and the fetch entry struct {instr, pc}.
- One sub-module: fetch_fifo. It is a parameterised synchronous FIFO with a flush input, push/pop, and a count output. fetch_queue owns the PC, credit and redirect logic.

## Test plan
- Reset release, dec_ready=1, memory returns addr+32'h100 → imem_addr 0,4,8,… one per cycle; first dec_valid in cycle 2 with dec_pc=0, dec_instr=32'h100; one pop per cycle thereafter.
- dec_ready=0 from reset → exactly 4 issues (addrs 0..12); occupancy saturates at 4 with inflight=0; imem_en stays 0. Raise dec_ready → PCs 0,4,8,12,16 delivered in order with no loss or duplication.
- Full queue, dec_ready pulsed for one cycle → occupancy 4→3→4. Exactly one new issue (addr 16); no overflow.
- Redirect to 32'h0000_0200 in the same cycle a response for addr 8 returns → addr-8 data discarded; occupancy=0 next cycle; imem_addr=32'h200 in r+1; first dec_pc=32'h200 in r+3.
- redirect_pc=32'hFFFF_FFFC → fetches 32'hFFFF_FFFC then 32'h0000_0000 (wrap).
- With FETCHQ_HALT_EN, word at addr 8 = 32'hFFFF_FFFF → halted rises at its enqueue; no issue beyond the already in-flight one; entries drain. A redirect to 0 clears halted and fetching resumes.
